// File: rtl/vga_chain_source_if.sv
// Raster bus leaving the head of the VGA chain: run request in, timing/pixel out.
// The master side is the timing generator; the slave side is the downstream chain.
interface vga_chain_source_if;
   logic        run;
   logic [9:0]  pxl_x;
   logic [9:0]  pxl_y;
   logic        en;
   logic        hsync;
   logic        vsync;
   logic [3:0]  red;
   logic [3:0]  green;
   logic [3:0]  blue;
   logic        line_start;
   logic        frame_start;
   logic [15:0] frame_cnt;
   logic        running;

   modport master (
      input  run,
      output pxl_x, pxl_y, en, hsync, vsync, red, green, blue,
             line_start, frame_start, frame_cnt, running
   );

   modport slave (
      output run,
      input  pxl_x, pxl_y, en, hsync, vsync, red, green, blue,
             line_start, frame_start, frame_cnt, running
   );
endinterface

// File: rtl/vga_chain_source.sv
// VGA timing generator at the head of the chain: raster counters, syncs, frame/line
// pulses and frame counter, with a run/stop that only stops on a frame boundary.
module vga_chain_source #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0
) (
   input  logic                  clk_25,
   input  logic                  resetN,
   vga_chain_source_if.master    vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t      state_r, state_nxt_s;
   logic [9:0]  h_cnt_r, v_cnt_r, h_cnt_nxt_s, v_cnt_nxt_s;
   logic        h_wrap_s, v_wrap_s;
   logic        hs_act_s, vs_act_s, frame_pix_s;
   logic [15:0] frame_cnt_nxt_s;

   logic [9:0]  pxl_x_r, pxl_y_r;
   logic        en_r, hsync_r, vsync_r, line_start_r, frame_start_r, running_r;
   logic [15:0] frame_cnt_r;

   // State and raster counter registers
   always_ff @(posedge clk_25 or negedge resetN) begin
      if (!resetN) begin
         state_r <= IDLE;
         h_cnt_r <= 10'd0;
         v_cnt_r <= 10'd0;
      end else begin
         state_r <= state_nxt_s;
         h_cnt_r <= h_cnt_nxt_s;
         v_cnt_r <= v_cnt_nxt_s;
      end
   end

   // Next state and counter advance; a stop request only takes effect on the last pixel
   always_comb begin
      state_nxt_s = state_r;
      h_cnt_nxt_s = 10'd0;
      v_cnt_nxt_s = 10'd0;
      h_wrap_s    = (h_cnt_r == H_LAST);
      v_wrap_s    = (v_cnt_r == V_LAST);
      case (state_r)
         IDLE: begin
            if (vga.run) state_nxt_s = RUN;
            else         state_nxt_s = IDLE;
         end
         RUN: begin
            if (h_wrap_s) begin
               h_cnt_nxt_s = 10'd0;
               if (v_wrap_s) begin
                  v_cnt_nxt_s = 10'd0;
                  if (!vga.run) state_nxt_s = IDLE;
                  else          state_nxt_s = RUN;
               end else begin
                  v_cnt_nxt_s = v_cnt_r + 10'd1;
               end
            end else begin
               h_cnt_nxt_s = h_cnt_r + 10'd1;
               v_cnt_nxt_s = v_cnt_r;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // Decode of the current raster position feeding the output register stage
   always_comb begin
      hs_act_s        = (h_cnt_r >= HS_START) && (h_cnt_r < HS_END);
      vs_act_s        = (v_cnt_r >= VS_START) && (v_cnt_r < VS_END);
      frame_pix_s     = (state_r == RUN) && (h_cnt_r == 10'd0) && (v_cnt_r == 10'd0);
      frame_cnt_nxt_s = frame_cnt_r + {15'd0, frame_pix_s};
   end

   // Registered outputs, one cycle behind the counters; blank while idle
   always_ff @(posedge clk_25 or negedge resetN) begin
      if (!resetN) begin
         pxl_x_r       <= 10'd0;
         pxl_y_r       <= 10'd0;
         en_r          <= 1'b0;
         hsync_r       <= ~HS_POL;
         vsync_r       <= ~VS_POL;
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
         running_r     <= 1'b0;
         frame_cnt_r   <= 16'd0;
      end else begin
         frame_cnt_r <= frame_cnt_nxt_s;
         if (state_r == RUN) begin
            pxl_x_r       <= h_cnt_r;
            pxl_y_r       <= v_cnt_r;
            en_r          <= (h_cnt_r < H_ACT) && (v_cnt_r < V_ACT);
            hsync_r       <= hs_act_s ? HS_POL : ~HS_POL;
            vsync_r       <= vs_act_s ? VS_POL : ~VS_POL;
            line_start_r  <= (h_cnt_r == 10'd0);
            frame_start_r <= frame_pix_s;
            running_r     <= 1'b1;
         end else begin
            pxl_x_r       <= 10'd0;
            pxl_y_r       <= 10'd0;
            en_r          <= 1'b0;
            hsync_r       <= ~HS_POL;
            vsync_r       <= ~VS_POL;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            running_r     <= 1'b0;
         end
      end
   end

   assign vga.pxl_x       = pxl_x_r;
   assign vga.pxl_y       = pxl_y_r;
   assign vga.en          = en_r;
   assign vga.hsync       = hsync_r;
   assign vga.vsync       = vsync_r;
   assign vga.line_start  = line_start_r;
   assign vga.frame_start = frame_start_r;
   assign vga.frame_cnt   = frame_cnt_r;
   assign vga.running     = running_r;
   assign vga.red         = 4'd0;
   assign vga.green       = 4'd0;
   assign vga.blue        = 4'd0;

endmodule

// File: doc/vga_chain_source.md
Name: vga_chain_source

Overview:
- Timing generator and head of the VGA chain; the pixel-producing end of the chain whose sink is the screen display block.
- Produces the raster position, active-video enable, sync strobes and black RGB that feed vga_chain_start.
- Also produces frame/line pulses and a frame counter for animation and vsync-driven logic.
- Supports a gated run/stop so the raster only stops on a frame boundary.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)

Ports:
- clk_25  in  1  pixel clock
- resetN  in  1  reset, asynchronous, active-low
- run  in  1  1 = generate raster; sampled each cycle
- pxl_x  out  10  horizontal counter, 0..H_TOTAL-1
- pxl_y  out  10  vertical counter, 0..V_TOTAL-1
- en  out  1  active video: pxl_x < H_ACTIVE and pxl_y < V_ACTIVE
- hsync  out  1  horizontal sync, polarity per HS_POL
- vsync  out  1  vertical sync, polarity per VS_POL
- red, green, blue  out  4 each  constant 0 (chain start is black)
- line_start  out  1  one-cycle pulse, output pixel has pxl_x = 0
- frame_start  out  1  one-cycle pulse, output pixel is (0,0)
- frame_cnt  out  16  count of frame_start pulses since reset
- running  out  1  1 while state = RUN

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800 by default). V_TOTAL likewise (525 by default).
- Internal counters: h_cnt and v_cnt.
  - h_cnt wraps at H_TOTAL-1 to 0.
  - v_cnt increments only on h_cnt wrap, and wraps at V_TOTAL-1 to 0.
- States:
  - IDLE: counters held at 0.
  - RUN: counters advance every cycle.
- Transitions:
  - IDLE -> RUN on the first edge sampling run = 1. Counters remain 0 on that edge.
  - RUN -> IDLE only at the last pixel (h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1) when run = 0 on that cycle; counters wrap to 0.
  - run = 0 at any other point in RUN is ignored until frame end, so the current frame always completes.
  - run re-asserted before frame end: no stop.
- Output stage: every output is registered from the state and counters of the previous cycle, giving 1-cycle latency.
  - With state = IDLE the outputs are blank: en = 0, syncs inactive, pxl_x = pxl_y = 0, pulses 0.
  - First active pixel (en = 1, 0,0, frame_start = 1, line_start = 1) appears on the 2nd edge after run is first sampled high.
- hsync is active for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751.
- vsync is active for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), i.e. lines 490..491, for the whole line duration.
- frame_cnt increments (mod 2^16, wraps 65535 -> 0) on the same edge that frame_start is asserted.
- Reset values:
  - All outputs 0, except hsync = ~HS_POL and vsync = ~VS_POL.
  - state = IDLE, counters 0, frame_cnt = 0.
- Reset mid-frame: immediate return to reset values.
  - After release, behaves as from power-up: needs run sampled high, and first pixel is 2 edges later.
- red/green/blue are tied to 0 in all states.

Test Plan:
- Reset release, run tied 1 -> run sampled at edge 1; edge 2 gives en = 1, pxl (0,0), frame_start = 1, frame_cnt = 1, running = 1.
- Steady RUN, one full frame -> line period 800 cycles; hsync low for exactly 96 cycles starting at pxl_x = 656; en high 307200 cycles per frame; vsync low 1600 cycles starting at pxl_y = 490, pxl_x = 0; frame period 420000 cycles.
- Drop run at pxl (100,200) -> frame completes through (799,524); next cycle blank with running = 0 and frame_cnt unchanged. Re-raise run -> frame_start 2 edges later and frame_cnt increments by 1.
- Pulse run low for 10 cycles mid-frame, then high before frame end -> no stop; frame_start recurs exactly 420000 cycles after the previous one.
- Assert resetN = 0 at pxl (300,100) for 3 cycles -> outputs go to reset values immediately, frame_cnt = 0; on release with run = 1, frame_start occurs at edge 2.
- Instantiate with HS_POL = 1, VS_POL = 1 and preload frame_cnt near wrap (force or 65536 frames with reduced H/V params) -> syncs idle low and pulse high; frame_cnt wraps 65535 -> 0 on frame_start.
